lsu_subword_ctrl: RTL and testbench

Load/store control stage between the execute datapath and the byte-array data memory. It decodes RISC-V `funct3` access size and signedness, aligns and sign/zero-extends load data, and performs sub-word stores (SB/SH) as a two-cycle read-modify-write. The RMW is needed because the memory always writes four consecutive bytes. The block drives the memory's `address`, `write_data`, `mem_write_enable` and `mem_read_enable`, and consumes its combinational `read_data`.

---
 rtl/lsu_subword_ctrl.sv | 133 +++++++++++++
 tb/tb_lsu_subword_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword_ctrl.sv
// Load/store control stage: funct3 decode, load alignment/extension, and SB/SH read-modify-write.
// Optional `LSU_MISALIGN_CHECK_EN enables misaligned H/HU/W detection (err + suppressed access).
module lsu_subword_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RMW  = 1'b1;

  logic [0:0]        state_q;
  logic [31:0]       merge_q;
  logic [ADDR_W-1:0] addr_q;

  logic              is_b;
  logic              is_h;
  logic              is_w;
  logic              illegal;
  logic              misaligned;
  logic              accept;
  logic              bad;
  logic              do_load;
  logic              do_sw;
  logic              do_sub;
  logic [ADDR_W-1:0] aligned_addr;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_ext;
  logic [31:0]       merge_d;

  assign req_ready    = (state_q == STATE_IDLE);
  assign accept       = req_valid && req_ready;
  assign aligned_addr = {req_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    is_b    = (req_funct3[1:0] == 2'b00);
    is_h    = (req_funct3[1:0] == 2'b01);
    is_w    = (req_funct3 == 3'b010);
    illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_write;
      default:                illegal = 1'b1;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    misaligned = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  assign bad     = illegal || misaligned;
  assign do_load = accept && !bad && !req_write;
  assign do_sw   = accept && !bad && req_write && is_w;
  assign do_sub  = accept && !bad && req_write && !is_w;

  // Lane extraction for loads; funct3[2] selects zero-extension.
  always_comb begin
    case (req_addr[1:0])
      2'b00:   sel_byte = mem_rdata[7:0];
      2'b01:   sel_byte = mem_rdata[15:8];
      2'b10:   sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (is_w)
      load_ext = mem_rdata;
    else if (is_h)
      load_ext = {{16{sel_half[15] & ~req_funct3[2]}}, sel_half};
    else
      load_ext = {{24{sel_byte[7] & ~req_funct3[2]}}, sel_byte};
  end

  always_comb begin
    merge_d = mem_rdata;
    if (is_b) begin
      case (req_addr[1:0])
        2'b00:   merge_d[7:0]   = req_wdata[7:0];
        2'b01:   merge_d[15:8]  = req_wdata[7:0];
        2'b10:   merge_d[23:16] = req_wdata[7:0];
        default: merge_d[31:24] = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      merge_d[31:16] = req_wdata[15:0];
    end else begin
      merge_d[15:0] = req_wdata[15:0];
    end
  end

  // Enables are gated by rst_n so nothing reaches memory while reset is held.
  assign mem_re    = rst_n && (do_load || do_sub);
  assign mem_we    = rst_n && ((state_q == STATE_RMW) || do_sw);
  assign mem_addr  = (state_q == STATE_RMW) ? addr_q : aligned_addr;
  assign mem_wdata = (state_q == STATE_RMW) ? merge_q : (do_sw ? req_wdata : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STATE_IDLE;
      load_data  <= '0;
      load_valid <= 1'b0;
      err        <= 1'b0;
      merge_q    <= '0;
      addr_q     <= '0;
    end else begin
      load_valid <= do_load;
      err        <= accept && bad;
      if (do_load)
        load_data <= load_ext;
      if (do_sub) begin
        merge_q <= merge_d;
        addr_q  <= aligned_addr;
      end
      state_q <= do_sub ? STATE_RMW : STATE_IDLE;
    end
  end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed bench for lsu_subword_ctrl with a 64-byte little-endian memory model.
module tb_lsu_subword_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  logic [5:0] wa;

  logic [2:0]  tf [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000, 3'b100};
  logic [31:0] ta [8] = '{32'h09, 32'h0A, 32'h0B, 32'h0A, 32'h0A, 32'h08, 32'h08, 32'h0A};
  logic [31:0] te [8] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                          32'h000080FF, 32'h00007F01, 32'h00000001, 32'h000000FF};

  lsu_subword_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .load_data(load_data), .load_valid(load_valid), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign wa = {mem_addr[5:2], 2'b00};
  assign mem_rdata = {mem[wa + 6'd3], mem[wa + 6'd2], mem[wa + 6'd1], mem[wa]};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[wa]        <= mem_wdata[7:0];
      mem[wa + 6'd1] <= mem_wdata[15:8];
      mem[wa + 6'd2] <= mem_wdata[23:16];
      mem[wa + 6'd3] <= mem_wdata[31:24];
    end
  end

  function automatic logic [31:0] word_at(input logic [5:0] a);
    return {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = d;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    drive(1'b1, 3'b010, 32'h4, 32'hFFFFFFFF);
    #2;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    cyc();
    rst_n = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
    cyc();

    // SW 0x04 then LW 0x04
    drive(1'b1, 3'b010, 32'h4, 32'hDEADBEEF);
    #1;
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_re", {31'd0, mem_re}, 32'd0);
    chk("sw_addr", mem_addr, 32'h4);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    cyc();
    req_valid = 1'b0;
    chk("sw_byte4", {24'd0, mem[4]}, 32'h000000EF);
    chk("sw_byte7", {24'd0, mem[7]}, 32'h000000DE);
    drive(1'b0, 3'b010, 32'h4, 32'h0);
    #1;
    chk("lw_re", {31'd0, mem_re}, 32'd1);
    chk("lw_we", {31'd0, mem_we}, 32'd0);
    cyc();
    req_valid = 1'b0;
    chk("lw_valid", {31'd0, load_valid}, 32'd1);
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_err", {31'd0, err}, 32'd0);
    cyc();
    chk("lw_valid_pulse", {31'd0, load_valid}, 32'd0);

    // SB into word 0x0C, with a LW held off during RMW
    drive(1'b1, 3'b010, 32'hC, 32'h11223344);
    cyc();
    drive(1'b1, 3'b000, 32'hE, 32'h123456AA);
    #1;
    chk("sb_re", {31'd0, mem_re}, 32'd1);
    chk("sb_we", {31'd0, mem_we}, 32'd0);
    cyc();
    drive(1'b0, 3'b010, 32'hC, 32'h0);
    #1;
    chk("rmw_ready", {31'd0, req_ready}, 32'd0);
    chk("rmw_we", {31'd0, mem_we}, 32'd1);
    chk("rmw_re", {31'd0, mem_re}, 32'd0);
    chk("rmw_addr", mem_addr, 32'hC);
    chk("rmw_wdata", mem_wdata, 32'h11AA3344);
    cyc();
    chk("held_load_valid", {31'd0, load_valid}, 32'd0);
    chk("post_rmw_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rmw_re", {31'd0, mem_re}, 32'd1);
    chk("sb_mem_word", word_at(6'hC), 32'h11AA3344);
    cyc();
    req_valid = 1'b0;
    chk("lw_after_sb_valid", {31'd0, load_valid}, 32'd1);
    chk("lw_after_sb_data", load_data, 32'h11AA3344);

    // Sub-word loads from word 0x08, back to back
    drive(1'b1, 3'b010, 32'h8, 32'h80FF7F01);
    cyc();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, tf[i], ta[i], 32'h0);
      cyc();
      chk($sformatf("ld%0d_valid", i), {31'd0, load_valid}, 32'd1);
      chk($sformatf("ld%0d_data", i), load_data, te[i]);
    end
    req_valid = 1'b0;
    cyc();

    // Misaligned LW 0x06 and LH 0x09
    drive(1'b0, 3'b010, 32'h6, 32'h0);
    #1;
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_lw_re", {31'd0, mem_re}, 32'd0);
    chk("mis_lw_we", {31'd0, mem_we}, 32'd0);
    cyc();
    drive(1'b0, 3'b001, 32'h9, 32'h0);
    chk("mis_lw_err", {31'd0, err}, 32'd1);
    chk("mis_lw_valid", {31'd0, load_valid}, 32'd0);
    cyc();
    req_valid = 1'b0;
    chk("mis_lh_err", {31'd0, err}, 32'd1);
    chk("mis_lh_valid", {31'd0, load_valid}, 32'd0);
`else
    chk("mis_lw_re", {31'd0, mem_re}, 32'd1);
    chk("mis_lw_addr", mem_addr, 32'h4);
    cyc();
    drive(1'b0, 3'b001, 32'h9, 32'h0);
    chk("mis_lw_err", {31'd0, err}, 32'd0);
    chk("mis_lw_data", load_data, 32'hDEADBEEF);
    cyc();
    req_valid = 1'b0;
    chk("mis_lh_err", {31'd0, err}, 32'd0);
    chk("mis_lh_data", load_data, 32'h00007F01);
`endif
    cyc();
    chk("err_not_sticky", {31'd0, err}, 32'd0);

    // Illegal store funct3=100 and illegal load funct3=011
    drive(1'b1, 3'b100, 32'h8, 32'h0);
    #1;
    chk("ill_st_we", {31'd0, mem_we}, 32'd0);
    chk("ill_st_re", {31'd0, mem_re}, 32'd0);
    cyc();
    drive(1'b0, 3'b011, 32'h8, 32'h0);
    chk("ill_st_err", {31'd0, err}, 32'd1);
    chk("ill_st_valid", {31'd0, load_valid}, 32'd0);
    chk("ill_st_mem", word_at(6'h8), 32'h80FF7F01);
    #1;
    chk("ill_ld_re", {31'd0, mem_re}, 32'd0);
    cyc();
    req_valid = 1'b0;
    chk("ill_ld_err", {31'd0, err}, 32'd1);
    chk("ill_ld_valid", {31'd0, load_valid}, 32'd0);

    // Back-to-back LW, LW, SW
    drive(1'b0, 3'b010, 32'h4, 32'h0);
    #1;
    chk("b2b_ready0", {31'd0, req_ready}, 32'd1);
    cyc();
    chk("b2b_lw0", load_data, 32'hDEADBEEF);
    chk("b2b_err_clear", {31'd0, err}, 32'd0);
    drive(1'b0, 3'b010, 32'hC, 32'h0);
    #1;
    chk("b2b_ready1", {31'd0, req_ready}, 32'd1);
    cyc();
    chk("b2b_lw1_valid", {31'd0, load_valid}, 32'd1);
    chk("b2b_lw1", load_data, 32'h11AA3344);
    drive(1'b1, 3'b010, 32'h10, 32'h01020304);
    #1;
    chk("b2b_sw_we", {31'd0, mem_we}, 32'd1);
    cyc();
    req_valid = 1'b0;
    chk("b2b_sw_valid", {31'd0, load_valid}, 32'd0);
    chk("b2b_sw_mem", word_at(6'h10), 32'h01020304);

    // SH interrupted by reset during RMW
    drive(1'b1, 3'b001, 32'h12, 32'h00005555);
    cyc();
    req_valid = 1'b0;
    chk("sh_rmw_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("sh_rst_we", {31'd0, mem_we}, 32'd0);
    chk("sh_rst_ready", {31'd0, req_ready}, 32'd1);
    cyc();
    chk("sh_rst_mem", word_at(6'h10), 32'h01020304);
    rst_n = 1'b1;
    cyc();
    chk("sh_rst_ready_rel", {31'd0, req_ready}, 32'd1);
    chk("sh_rst_load_data", load_data, 32'd0);

    // SH completing normally, then LH readback
    drive(1'b1, 3'b001, 32'h12, 32'hFFFF5555);
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("sh_mem", word_at(6'h10), 32'h55550304);
    drive(1'b0, 3'b001, 32'h12, 32'h0);
    cyc();
    req_valid = 1'b0;
    chk("lh_sh_data", load_data, 32'h00005555);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
